// File: rtl/immgen_pipe.sv
// -----------------------------------------------------------------------------
// immgen_pipe
//
// Pipelined immediate generator for the decode stage. It decodes the immediate
// of an instruction word combinationally on the input side, then registers the
// result in a two-entry buffer: a main register that drives the outputs, and a
// skid register.
//
// Both sides use a valid/ready handshake. A sideband tag, such as a PC or a ROB
// index, travels with each immediate unmodified. Flush discards everything that
// is buffered.
//
// Parameters:
//   XLEN   datapath width, 32 or 64 only
//   TAG_W  width of the sideband tag
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous discard of both entries; blocks accept this cycle
//   in_valid   upstream offers an instruction
//   in_ready   block can accept this cycle (registered state and flush only)
//   in_instr   instruction word; bits [6:0] are not used
//   in_sel     immediate format select
//   in_tag     sideband tag
//   out_valid  result available (main entry valid)
//   out_ready  downstream accepts the result
//   out_imm    generated immediate
//   out_tag    tag of the result
//   out_err    the format select was illegal for this entry
// -----------------------------------------------------------------------------
module immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("immgen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] SEL_I     = 3'b000;
    localparam logic [2:0] SEL_S     = 3'b001;
    localparam logic [2:0] SEL_B     = 3'b010;
    localparam logic [2:0] SEL_J     = 3'b011;
    localparam logic [2:0] SEL_U     = 3'b100;
    localparam logic [2:0] SEL_SHAMT = 3'b101;
    localparam logic [2:0] SEL_ZIMM  = 3'b110;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    logic [63:0] w_imm64;
    logic        w_err;
    entry_t      w_new;
    logic        w_accept;
    logic        w_main_free;
    logic        w_unused;

    entry_t r_main;
    entry_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;

    // The immediate is always built 64 bits wide. For XLEN=32 it is truncated,
    // which gives the same sign extension from bit 31.
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_imm64 = '0;
        w_err   = 1'b0;
        case (in_sel)
            SEL_I:     w_imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
            SEL_S:     w_imm64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            SEL_B:     w_imm64 = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0};
            SEL_J:     w_imm64 = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0};
            SEL_U:     w_imm64 = {{32{in_instr[31]}}, in_instr[31:12], 12'h000};
            SEL_SHAMT: begin
                if (XLEN == 64) begin
                    w_imm64 = {58'd0, in_instr[25:20]};
                end else begin
                    // RV32 shift amounts are only 5 bits. Bit 25 set is
                    // flagged as an error, but the immediate is still produced.
                    w_imm64 = {59'd0, in_instr[24:20]};
                    w_err   = in_instr[25];
                end
            end
            SEL_ZIMM:  w_imm64 = {59'd0, in_instr[19:15]};
            default:   w_err   = 1'b1;
        endcase
    end

    assign w_new.imm = w_imm64[XLEN-1:0];
    assign w_new.tag = in_tag;
    assign w_new.err = w_err;

    // The opcode field and, for XLEN=32, the upper half of the 64-bit build
    // are intentionally not used.
    assign w_unused = ^{in_instr[6:0], w_imm64};

    // Ready depends only on registered state and flush. This keeps out_ready
    // off the upstream ready path.
    assign in_ready    = !r_skid_valid && !flush;
    assign w_accept    = in_valid && in_ready;
    assign w_main_free = !r_main_valid || out_ready;

    // NOTE: state is updated with non-blocking assignments only. Every register
    // then samples pre-edge values, so the skid-to-main move and the accept in
    // the same cycle do not race.
    // NOTE: the data registers are reset along with the valid bits, because the
    // outputs must read zero during and after reset, not just be marked invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                // The older skid entry advances first to preserve FIFO order.
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= w_accept;
                if (w_accept) begin
                    r_skid <= w_new;
                end
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main <= w_new;
                end
            end
        end else if (w_accept) begin
            // Main is stalled, so the new entry parks in the skid register.
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid = r_main_valid;
    assign out_imm   = r_main.imm;
    assign out_tag   = r_main.tag;
    assign out_err   = r_main.err;

endmodule

// File: tb/tb_immgen_pipe.sv
// -----------------------------------------------------------------------------
// tb_immgen_pipe
//
// Runs an XLEN=32 and an XLEN=64 instance side by side on shared inputs.
//
// The reference model is a two-deep FIFO queue of expected results. Each
// immediate is computed with signed integer arithmetic directly from the
// format definitions.
// -----------------------------------------------------------------------------
module tb_immgen_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_sel;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32, out_tag32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;

    int checks = 0;
    int errors = 0;

    immgen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
    );

    immgen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [31:0] tag;
        logic        err32;
        logic        err64;
    } exp_t;

    exp_t mq[$];

    // Returns {err, imm}. The imm is the 64-bit value; XLEN=32 uses the low half.
    function automatic logic [64:0] ref_fmt(input logic [31:0] ins, input logic [2:0] sel,
                                            input bit x64);
        longint s;
        longint v;
        bit     e;
        s = longint'($signed(ins));
        e = 1'b0;
        v = 0;
        case (sel)
            3'd0: v = s >>> 20;
            3'd1: v = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
            3'd2: v = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                      | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            3'd3: v = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                      | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            3'd4: v = (s >>> 12) <<< 12;
            3'd5: begin
                if (x64) begin
                    v = longint'(ins[25:20]);
                end else begin
                    v = longint'(ins[24:20]);
                    e = ins[25];
                end
            end
            3'd6: v = longint'(ins[19:15]);
            default: begin
                v = 0;
                e = 1'b1;
            end
        endcase
        return {e, v};
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit          acc;
        exp_t        e;
        logic [64:0] r32;
        logic [64:0] r64;
        if (rst) begin
            mq.delete();
        end else begin
            acc = in_valid && (mq.size() < 2) && !flush;
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && out_ready) begin
                    void'(mq.pop_front());
                end
                if (acc) begin
                    r32     = ref_fmt(in_instr, in_sel, 1'b0);
                    r64     = ref_fmt(in_instr, in_sel, 1'b1);
                    e.imm32 = r32[31:0];
                    e.err32 = r32[64];
                    e.imm64 = r64[63:0];
                    e.err64 = r64[64];
                    e.tag   = in_tag;
                    mq.push_back(e);
                end
            end
        end
    end

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_sel = '0; in_tag = '0; out_ready = 1'b0;
        #12;
        checks++;
        if ({out_valid32, out_err32, out_tag32, out_imm32, in_ready32} !== {2'b00, 64'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset32 got v=%b e=%b t=%h i=%h r=%b want 0 0 0 0 1",
                     out_valid32, out_err32, out_tag32, out_imm32, in_ready32);
        end
        checks++;
        if ({out_valid64, out_err64, out_tag64, out_imm64, in_ready64} !== {2'b00, 96'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset64 got v=%b e=%b t=%h i=%h r=%b want 0 0 0 0 1",
                     out_valid64, out_err64, out_tag64, out_imm64, in_ready64);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_formats();
        logic [31:0] t_ins[8] = '{32'hFFF00093, 32'h800002B7, 32'h03F00000, 32'hFE000EE3,
                                  32'hFE000EE3, 32'h000F8000, 32'hFE000FA3, 32'h0010006F};
        logic [2:0]  t_sel[8] = '{3'd0, 3'd4, 3'd5, 3'd2, 3'd7, 3'd6, 3'd1, 3'd3};
        logic [31:0] t_e32[8] = '{32'hFFFFFFFF, 32'h80000000, 32'h0000001F, 32'hFFFFFFFC,
                                  32'h0, 32'h1F, 32'hFFFFFFFF, 32'h800};
        logic [63:0] t_e64[8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h3F,
                                  64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h1F,
                                  64'hFFFFFFFFFFFFFFFF, 64'h800};
        logic        t_r32[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        t_r64[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] tag;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tag      = (i == 0) ? 32'd5 : 32'd16 + 32'(i);
            in_valid = 1'b1;
            in_instr = t_ins[i];
            in_sel   = t_sel[i];
            in_tag   = tag;
            tick();
            checks++;
            if ({out_valid32, out_imm32, out_tag32, out_err32} !== {1'b1, t_e32[i], tag, t_r32[i]}) begin
                errors++;
                $display("FAIL fmt32[%0d] got v=%b i=%h t=%h e=%b want 1 %h %h %b", i,
                         out_valid32, out_imm32, out_tag32, out_err32, t_e32[i], tag, t_r32[i]);
            end
            checks++;
            if ({out_valid64, out_imm64, out_tag64, out_err64} !== {1'b1, t_e64[i], tag, t_r64[i]}) begin
                errors++;
                $display("FAIL fmt64[%0d] got v=%b i=%h t=%h e=%b want 1 %h %h %b", i,
                         out_valid64, out_imm64, out_tag64, out_err64, t_e64[i], tag, t_r64[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq32[$];
        logic [31:0] seq64[$];
        int          first_k;
        int          last_k;
        bit          acc_now;
        out_ready = 1'b0;
        in_instr  = 32'h00100093;
        in_sel    = 3'd0;
        in_valid  = 1'b1;
        in_tag    = 32'd1;
        tick();
        in_tag = 32'd2;
        tick();
        in_tag = 32'd3;
        checks++;
        if ({in_ready32, in_ready64} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_full_ready got %b%b want 00", in_ready32, in_ready64);
        end
        tick();
        checks++;
        if ({out_valid32, out_tag32, in_ready32} !== {1'b1, 32'd1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_stall got v=%b t=%0d r=%b want 1 1 0", out_valid32, out_tag32, in_ready32);
        end
        out_ready = 1'b1;
        first_k   = -1;
        last_k    = -1;
        for (int k = 0; k < 8; k++) begin
            if (out_valid32) begin
                seq32.push_back(out_tag32);
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (out_valid64) seq64.push_back(out_tag64);
            acc_now = in_valid && (mq.size() < 2) && !flush;
            tick();
            if (acc_now) in_valid = 1'b0;
        end
        checks++;
        if (seq32.size() != 3 || seq32[0] !== 32'd1 || seq32[1] !== 32'd2 || seq32[2] !== 32'd3) begin
            errors++;
            $display("FAIL b2b_order32 got %p want 1 2 3", seq32);
        end
        checks++;
        if (seq64.size() != 3 || seq64[0] !== 32'd1 || seq64[1] !== 32'd2 || seq64[2] !== 32'd3) begin
            errors++;
            $display("FAIL b2b_order64 got %p want 1 2 3", seq64);
        end
        checks++;
        if (first_k < 0 || last_k - first_k > 4) begin
            errors++;
            $display("FAIL b2b_gaps got span %0d..%0d want at most 4 cycles", first_k, last_k);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_instr  = 32'h00500093;
        in_sel    = 3'd0;
        in_valid  = 1'b1;
        in_tag    = 32'd20;
        tick();
        in_tag = 32'd21;
        tick();
        flush  = 1'b1;
        in_tag = 32'd22;
        #1;
        checks++;
        if ({in_ready32, in_ready64} !== 2'b00) begin
            errors++;
            $display("FAIL flush_full_ready got %b%b want 00", in_ready32, in_ready64);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid32, out_valid64} !== 2'b00) begin
            errors++;
            $display("FAIL flush_clear got %b%b want 00", out_valid32, out_valid64);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({out_valid32, out_valid64} !== 2'b00) begin
                errors++;
                $display("FAIL flush_ghost[%0d] got %b%b tag %0d want 00", k,
                         out_valid32, out_valid64, out_tag32);
            end
        end
        // With only main occupied, flush alone must still drop in_ready.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'd23;
        tick();
        flush  = 1'b1;
        in_tag = 32'd24;
        #1;
        checks++;
        if ({in_ready32, in_ready64} !== 2'b00) begin
            errors++;
            $display("FAIL flush_half_ready got %b%b want 00", in_ready32, in_ready64);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid32, out_valid64} !== 2'b00) begin
            errors++;
            $display("FAIL flush_half_clear got %b%b want 00", out_valid32, out_valid64);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h800002B7;
        in_sel    = 3'd4;
        in_tag    = 32'd30;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid32, out_tag32} !== {1'b1, 32'd30}) begin
            errors++;
            $display("FAIL arst_pre got v=%b t=%0d want 1 30", out_valid32, out_tag32);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid32, out_valid64, out_imm32, out_imm64, out_tag32, out_err32, in_ready32}
                !== {2'b00, 96'd0, 32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL arst_immediate got v=%b%b i=%h/%h t=%h e=%b r=%b want zeros r=1",
                     out_valid32, out_valid64, out_imm32, out_imm64, out_tag32, out_err32, in_ready32);
        end
        tick();
        rst = 1'b0;
        checks++;
        if ({out_valid64, out_imm64, out_tag64, out_err64, in_ready64} !== {1'b0, 96'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL arst_release got v=%b i=%h t=%h e=%b r=%b want zeros r=1",
                     out_valid64, out_imm64, out_tag64, out_err64, in_ready64);
        end
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_sel    = 3'd0;
        in_tag    = 32'd31;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid32, out_tag32, out_imm32} !== {1'b1, 32'd31, 32'hFFFFFFFF}) begin
            errors++;
            $display("FAIL arst_first got v=%b t=%0d i=%h want 1 31 ffffffff",
                     out_valid32, out_tag32, out_imm32);
        end
        tick();
    endtask

    task automatic test_random();
        logic [66:0] got32, exp32;
        logic [98:0] got64, exp64;
        logic        exp_rdy;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            in_instr  = $urandom;
            in_sel    = 3'($urandom_range(0, 7));
            in_tag    = $urandom;
            tick();
            exp_rdy = (mq.size() < 2) && !flush;
            got32   = {out_valid32, in_ready32, 65'd0};
            got64   = {out_valid64, in_ready64, 97'd0};
            exp32   = {1'b0, exp_rdy, 65'd0};
            exp64   = {1'b0, exp_rdy, 97'd0};
            if (out_valid32) got32[64:0] = {out_imm32, out_tag32, out_err32};
            if (out_valid64) got64[96:0] = {out_imm64, out_tag64, out_err64};
            if (mq.size() > 0) begin
                exp32 = {1'b1, exp_rdy, mq[0].imm32, mq[0].tag, mq[0].err32};
                exp64 = {1'b1, exp_rdy, mq[0].imm64, mq[0].tag, mq[0].err64};
            end
            checks++;
            if (got32 !== exp32) begin
                errors++;
                $display("FAIL rand32[%0d] got %h want %h", n, got32, exp32);
            end
            checks++;
            if (got64 !== exp64) begin
                errors++;
                $display("FAIL rand64[%0d] got %h want %h", n, got64, exp64);
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
